// File: rtl/apbDecode_package.sv
// Shared types for the APB command requester: command/response records and FSM states.
package apbDecode_package;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;
  localparam int APB_STRB_W = APB_DATA_W / 8;

  typedef struct packed {
    logic                  write;
    logic [APB_ADDR_W-1:0] addr;
    logic [APB_DATA_W-1:0] wdata;
    logic [APB_STRB_W-1:0] strb;
  } apb_cmd_t;

  typedef struct packed {
    logic [APB_DATA_W-1:0] rdata;
    logic                  err;
    logic                  timeout;
  } apb_rsp_t;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } apb_mst_state_e;

endpackage

// File: rtl/apb_cmd_fifo.sv
// Synchronous command FIFO; a push while full is refused even if a pop happens that cycle.
module apb_cmd_fifo
  import apbDecode_package::*;
#(
  parameter int DEPTH = 4,
  parameter int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  apb_cmd_t         din,
  output logic             full,
  input  logic             pop,
  output apb_cmd_t         dout,
  output logic             empty,
  output logic [LVL_W-1:0] level
);

  localparam int PTR_W = $clog2(DEPTH);

  apb_cmd_t         mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == LVL_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];
  assign level   = count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + LVL_W'(1);
        2'b01:   count <= count - LVL_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is data only; occupancy is tracked by the pointers and count
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/apb_cmd_master.sv
// APB3/APB4 requester: buffers valid/ready commands, runs SETUP/ACCESS transfers, returns responses.
module apb_cmd_master
  import apbDecode_package::*;
#(
  parameter int ADDR_W  = APB_ADDR_W,
  parameter int DATA_W  = APB_DATA_W,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_write,
  input  logic [ADDR_W-1:0]        cmd_addr,
  input  logic [DATA_W-1:0]        cmd_wdata,
  input  logic [DATA_W/8-1:0]      cmd_strb,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [DATA_W-1:0]        rsp_rdata,
  output logic                     rsp_err,
  output logic                     rsp_timeout,
  output logic                     psel,
  output logic                     penable,
  output logic                     pwrite,
  output logic [ADDR_W-1:0]        paddr,
  output logic [DATA_W-1:0]        pwdata,
  output logic [DATA_W/8-1:0]      pstrb,
  input  logic [DATA_W-1:0]        prdata,
  input  logic                     pready,
  input  logic                     pslverr,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     busy
);

  localparam int STRB_W = DATA_W / 8;
  localparam int LVL_W  = $clog2(DEPTH) + 1;
  // A 1-bit counter is kept when the timeout is disabled so the width stays legal
  localparam int CNT_W  = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(TIMEOUT);

  apb_mst_state_e   state;
  apb_mst_state_e   state_n;
  apb_cmd_t         cmd_in;
  apb_cmd_t         head;
  apb_rsp_t         rsp_q;
  logic [CNT_W-1:0] wait_cnt;
  logic             full;
  logic             empty;
  logic             pop;
  logic             done;
  logic             abort;

  always_comb begin
    cmd_in       = '0;
    cmd_in.write = cmd_write;
    cmd_in.addr  = APB_ADDR_W'(cmd_addr);
    cmd_in.wdata = APB_DATA_W'(cmd_wdata);
    cmd_in.strb  = APB_STRB_W'(cmd_strb);
  end

  apb_cmd_fifo #(
    .DEPTH (DEPTH),
    .LVL_W (LVL_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (cmd_valid),
    .din   (cmd_in),
    .full  (full),
    .pop   (pop),
    .dout  (head),
    .empty (empty),
    .level (level)
  );

  assign cmd_ready   = !full;
  assign psel        = (state == SETUP) || (state == ACCESS);
  assign penable     = (state == ACCESS);
  assign rsp_valid   = (state == RESP);
  assign rsp_rdata   = DATA_W'(rsp_q.rdata);
  assign rsp_err     = rsp_q.err;
  assign rsp_timeout = rsp_q.timeout;
  assign busy        = (state != IDLE) || !empty;

  always_comb begin
    state_n = state;
    pop     = 1'b0;
    done    = 1'b0;
    abort   = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_n = SETUP;
        end
      end
      SETUP: state_n = ACCESS;
      ACCESS: begin
        if (pready) begin
          done    = 1'b1;
          state_n = RESP;
        end else if ((TIMEOUT != 0) && (wait_cnt == TO_VAL)) begin
          abort   = 1'b1;
          state_n = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      wait_cnt <= '0;
      pwrite   <= 1'b0;
      paddr    <= '0;
      pwdata   <= '0;
      pstrb    <= '0;
      rsp_q    <= '0;
    end else begin
      state <= state_n;
      // APB address/data are loaded once per transfer and otherwise hold
      if (pop) begin
        pwrite <= head.write;
        paddr  <= ADDR_W'(head.addr);
        pwdata <= DATA_W'(head.wdata);
        pstrb  <= STRB_W'(head.strb);
      end
      if (pop) begin
        wait_cnt <= '0;
      end else if ((state == ACCESS) && !pready && (wait_cnt != CNT_MAX)) begin
        wait_cnt <= wait_cnt + CNT_W'(1);
      end
      if (done) begin
        rsp_q.rdata   <= pwrite ? '0 : APB_DATA_W'(prdata);
        rsp_q.err     <= pslverr;
        rsp_q.timeout <= 1'b0;
      end else if (abort) begin
        rsp_q.rdata   <= '0;
        rsp_q.err     <= 1'b1;
        rsp_q.timeout <= 1'b1;
      end
    end
  end

endmodule
